// File: rtl/rr_reg_arbiter_pkg.sv
// Shared types and default parameters for the round-robin register arbiter.
package rr_reg_arbiter_pkg;

    localparam int unsigned DEF_N_REQ    = 4;
    localparam int unsigned DEF_WIDTH    = 6;
    localparam int unsigned DEF_MAX_HOLD = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

endpackage

// File: rtl/rr_reg_arbiter_if.sv
// Request/grant/register bus between the requesters and the arbiter.
interface rr_reg_arbiter_if
    import rr_reg_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned WIDTH = DEF_WIDTH
);
    localparam int unsigned IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       i_req;
    logic [N_REQ*WIDTH-1:0] i_data;
    logic [N_REQ-1:0]       o_gnt;
    logic [IDX_W-1:0]       o_owner;
    logic [WIDTH-1:0]       o_q;
    logic                   o_busy;

    modport master (
        output i_req, i_data,
        input  o_gnt, o_owner, o_q, o_busy
    );

    modport slave (
        input  i_req, i_data,
        output o_gnt, o_owner, o_q, o_busy
    );
endinterface

// File: rtl/rr_reg_arbiter_pick.sv
// Wrapping priority search: first set request bit at or above ptr, modulo N_REQ.
module rr_pick
    import rr_reg_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] pick,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        int unsigned cand;
        logic        found;
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= N_REQ) cand = cand - N_REQ;
            if (!found && req[IDX_W'(cand)]) begin
                found                = 1'b1;
                pick[IDX_W'(cand)]   = 1'b1;
                idx                  = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter owning a shared register; the owner writes it every cycle it
// keeps its request up, and is forced off after MAX_HOLD cycles if others wait.
module rr_reg_arbiter
    import rr_reg_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ    = DEF_N_REQ,
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                i_clk,
    input  logic                i_rst,
    rr_reg_arbiter_if.slave     bus
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned HC_W  = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    state_t             state;
    logic [N_REQ-1:0]   gnt;
    logic [IDX_W-1:0]   owner;
    logic               busy;
    logic [IDX_W-1:0]   ptr;
    logic [HC_W-1:0]    hold_cnt;
    logic [WIDTH-1:0]   q;

    logic [N_REQ-1:0]   pick_c;
    logic [IDX_W-1:0]   pick_idx_c;
    logic               start_c;
    logic               owner_req_c;
    logic               others_c;
    logic               at_limit_c;
    logic               release_c;
    logic               write_c;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req  (bus.i_req),
        .ptr  (ptr),
        .pick (pick_c),
        .idx  (pick_idx_c)
    );

    // Decisions for this edge; dropping the request wins over forced release.
    always_comb begin
        start_c     = 1'b0;
        owner_req_c = 1'b0;
        others_c    = 1'b0;
        at_limit_c  = 1'b0;
        release_c   = 1'b0;
        write_c     = 1'b0;
        if (state == IDLE) begin
            start_c = |bus.i_req;
        end else begin
            owner_req_c = bus.i_req[owner];
            others_c    = |(bus.i_req & ~gnt);
            at_limit_c  = (hold_cnt == HC_W'(MAX_HOLD - 1));
            write_c     = owner_req_c;
            release_c   = !owner_req_c || (at_limit_c && others_c);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= IDLE;
            gnt   <= '0;
            owner <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_c) begin
                    state <= OWN;
                    gnt   <= pick_c;
                    owner <= pick_idx_c;
                    busy  <= 1'b1;
                end
                OWN: if (release_c) begin
                    state <= IDLE;
                    gnt   <= '0;
                    owner <= '0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    owner <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Next search starts just above whoever leaves.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            ptr <= '0;
        end else if (release_c) begin
            ptr <= (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + IDX_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            hold_cnt <= '0;
        end else if (start_c) begin
            hold_cnt <= '0;
        end else if (state == OWN && !at_limit_c) begin
            hold_cnt <= hold_cnt + HC_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            q <= '0;
        end else if (write_c) begin
            q <= bus.i_data[int'(owner)*WIDTH +: WIDTH];
        end
    end

    assign bus.o_gnt   = gnt;
    assign bus.o_owner = owner;
    assign bus.o_q     = q;
    assign bus.o_busy  = busy;

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Directed bench for rr_reg_arbiter with hand-computed expectations (N_REQ=4, WIDTH=6, MAX_HOLD=8).
module tb_rr_reg_arbiter;

    logic i_clk = 1'b0;
    logic i_rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 i_clk = ~i_clk;

    rr_reg_arbiter_if #(.N_REQ(4), .WIDTH(6)) bus ();

    rr_reg_arbiter #(.N_REQ(4), .WIDTH(6), .MAX_HOLD(8)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_data(input int k, input logic [5:0] v);
        bus.i_data[k*6 +: 6] = v;
    endtask

    task automatic do_reset();
        i_rst      = 1'b0;
        bus.i_req  = '0;
        bus.i_data = '0;
        repeat (2) @(posedge i_clk);
        #3;
        i_rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        i_rst      = 1'b0;
        bus.i_data = '1;
        bus.i_req  = 4'b0101;
        tick();
        tick();
        total++; if (bus.o_gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b want=0000", bus.o_gnt); end
        total++; if (bus.o_owner !== 2'd0) begin bad++; $display("FAIL reset_owner got=%0d want=0", bus.o_owner); end
        total++; if (bus.o_q !== 6'h00) begin bad++; $display("FAIL reset_q got=%h want=00", bus.o_q); end
        total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.o_busy); end
    endtask

    task automatic test_single();
        do_reset();
        set_data(2, 6'h15);
        bus.i_req = 4'b0100;
        tick();
        total++; if (bus.o_gnt !== 4'b0100) begin bad++; $display("FAIL single_gnt got=%b want=0100", bus.o_gnt); end
        total++; if (bus.o_owner !== 2'd2 || bus.o_busy !== 1'b1) begin bad++; $display("FAIL single_owner got=%0d/%b want=2/1", bus.o_owner, bus.o_busy); end
        total++; if (bus.o_q !== 6'h00) begin bad++; $display("FAIL single_q_early got=%h want=00", bus.o_q); end
        tick();
        total++; if (bus.o_q !== 6'h15) begin bad++; $display("FAIL single_q got=%h want=15", bus.o_q); end
        bus.i_req = 4'b0000;
        set_data(2, 6'h3A);
        tick();
        total++; if (bus.o_gnt !== 4'b0000 || bus.o_busy !== 1'b0) begin bad++; $display("FAIL single_drop got=%b/%b want=0000/0", bus.o_gnt, bus.o_busy); end
        total++; if (bus.o_q !== 6'h15) begin bad++; $display("FAIL single_drop_q got=%h want=15", bus.o_q); end
        tick();
        total++; if (bus.o_gnt !== 4'b0000 || bus.o_q !== 6'h15) begin bad++; $display("FAIL idle_hold got=%b/%h want=0000/15", bus.o_gnt, bus.o_q); end
    endtask

    task automatic test_rotate();
        int          order [5] = '{0, 1, 2, 3, 0};
        logic [3:0]  eg;
        logic [5:0]  eq;
        do_reset();
        for (int k = 0; k < 4; k++) set_data(k, 6'(6'h10 + k));
        bus.i_req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            eg = 4'(1 << order[i]);
            eq = 6'(6'h10 + order[i]);
            for (int c = 0; c < 8; c++) begin
                tick();
                total++; if (bus.o_gnt !== eg || bus.o_busy !== 1'b1) begin bad++; $display("FAIL rotate_gnt slot=%0d cyc=%0d got=%b want=%b", i, c, bus.o_gnt, eg); end
            end
            total++; if (bus.o_q !== eq) begin bad++; $display("FAIL rotate_q slot=%0d got=%h want=%h", i, bus.o_q, eq); end
            tick();
            total++; if (bus.o_gnt !== 4'b0000 || bus.o_busy !== 1'b0) begin bad++; $display("FAIL rotate_bubble slot=%0d got=%b want=0000", i, bus.o_gnt); end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        bus.i_req = 4'b1000;
        tick();
        total++; if (bus.o_gnt !== 4'b1000 || bus.o_owner !== 2'd3) begin bad++; $display("FAIL wrap_own3 got=%b/%0d want=1000/3", bus.o_gnt, bus.o_owner); end
        bus.i_req = 4'b0011;
        tick();
        total++; if (bus.o_gnt !== 4'b0000) begin bad++; $display("FAIL wrap_idle got=%b want=0000", bus.o_gnt); end
        tick();
        total++; if (bus.o_gnt !== 4'b0001 || bus.o_owner !== 2'd0) begin bad++; $display("FAIL wrap_gnt0 got=%b/%0d want=0001/0", bus.o_gnt, bus.o_owner); end
    endtask

    task automatic test_sole();
        logic [5:0] v;
        do_reset();
        bus.i_req = 4'b0010;
        tick();
        total++; if (bus.o_gnt !== 4'b0010 || bus.o_owner !== 2'd1) begin bad++; $display("FAIL sole_gnt got=%b/%0d want=0010/1", bus.o_gnt, bus.o_owner); end
        for (int c = 0; c < 20; c++) begin
            v = 6'(c * 3 + 1);
            set_data(1, v);
            tick();
            total++; if (bus.o_gnt !== 4'b0010 || bus.o_q !== v) begin bad++; $display("FAIL sole_track cyc=%0d got=%b/%h want=0010/%h", c, bus.o_gnt, bus.o_q, v); end
        end
        bus.i_req = 4'b0011;
        set_data(1, 6'h2E);
        tick();
        total++; if (bus.o_gnt !== 4'b0000 || bus.o_q !== 6'h2E) begin bad++; $display("FAIL forced_release got=%b/%h want=0000/2e", bus.o_gnt, bus.o_q); end
        tick();
        total++; if (bus.o_gnt !== 4'b0001 || bus.o_owner !== 2'd0) begin bad++; $display("FAIL forced_next got=%b/%0d want=0001/0", bus.o_gnt, bus.o_owner); end
    endtask

    task automatic test_drop_at_limit();
        do_reset();
        set_data(2, 6'h2A);
        bus.i_req = 4'b0100;
        tick();
        repeat (7) tick();
        total++; if (bus.o_gnt !== 4'b0100 || bus.o_q !== 6'h2A) begin bad++; $display("FAIL limit_own got=%b/%h want=0100/2a", bus.o_gnt, bus.o_q); end
        bus.i_req = 4'b0001;
        set_data(2, 6'h3F);
        tick();
        total++; if (bus.o_gnt !== 4'b0000 || bus.o_q !== 6'h2A) begin bad++; $display("FAIL limit_drop got=%b/%h want=0000/2a", bus.o_gnt, bus.o_q); end
        tick();
        total++; if (bus.o_gnt !== 4'b0001 || bus.o_owner !== 2'd0) begin bad++; $display("FAIL limit_next got=%b/%0d want=0001/0", bus.o_gnt, bus.o_owner); end
    endtask

    task automatic test_async_reset();
        do_reset();
        set_data(2, 6'h15);
        bus.i_req = 4'b0100;
        tick();
        tick();
        total++; if (bus.o_q !== 6'h15 || bus.o_gnt !== 4'b0100) begin bad++; $display("FAIL arst_pre got=%b/%h want=0100/15", bus.o_gnt, bus.o_q); end
        #2;
        i_rst = 1'b0;
        #1;
        total++; if (bus.o_gnt !== 4'b0000 || bus.o_busy !== 1'b0) begin bad++; $display("FAIL arst_gnt got=%b/%b want=0000/0", bus.o_gnt, bus.o_busy); end
        total++; if (bus.o_q !== 6'h00 || bus.o_owner !== 2'd0) begin bad++; $display("FAIL arst_q got=%h/%0d want=00/0", bus.o_q, bus.o_owner); end
        bus.i_req = 4'b0110;
        @(negedge i_clk);
        i_rst = 1'b1;
        tick();
        total++; if (bus.o_gnt !== 4'b0010 || bus.o_owner !== 2'd1) begin bad++; $display("FAIL arst_first got=%b/%0d want=0010/1", bus.o_gnt, bus.o_owner); end
    endtask

    initial begin
        bus.i_req  = '0;
        bus.i_data = '0;
        test_reset();
        test_single();
        test_rotate();
        test_wrap();
        test_sole();
        test_drop_at_limit();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_reg_arbiter.md
RR_REG_ARBITER -- requirements
Module: rr_reg_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters, range 2..8.
REQ-002 Parameter WIDTH, default 6: width of the shared register.
REQ-003 Parameter MAX_HOLD, default 8: maximum consecutive owned cycles while another requester waits, range 1..255.
REQ-004 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-005 i_rst  input  1  reset, asynchronous and active-low.
REQ-006 i_req  input  N_REQ  per-requester request/lock; bit k high = requester k wants or keeps ownership.
REQ-007 i_data  input  N_REQ*WIDTH  per-requester write data; slice k = bits [k*WIDTH +: WIDTH].
REQ-008 o_gnt  output  N_REQ  registered one-hot grant; all-zero when no owner.
REQ-009 o_owner  output  clog2(N_REQ)  index of current owner; 0 when idle.
REQ-010 o_q  output  WIDTH  shared register contents.
REQ-011 o_busy  output  1  high while the state is OWN.

Function
REQ-012 The FSM SHALL have two states, IDLE and OWN, held in a registered state variable.
REQ-013 In IDLE with i_req nonzero, the next edge SHALL enter OWN and grant the first set bit searching upward from ptr, wrapping modulo N_REQ.
REQ-014 In IDLE with i_req zero, the state, o_gnt and ptr SHALL hold.
REQ-015 Grant latency SHALL be exactly one cycle: a request sampled in IDLE at edge t appears as o_gnt at edge t+1.
REQ-016 On every edge in OWN with i_req[owner]=1, o_q SHALL load the owner's i_data slice.
REQ-017 In OWN, o_q SHALL hold whenever i_req[owner]=0; it SHALL also hold in IDLE.
REQ-018 In OWN, i_req[owner]=0 SHALL return the FSM to IDLE at the next edge and clear o_gnt.
REQ-019 hold_cnt SHALL clear on entry to OWN and increment each OWN cycle, saturating at MAX_HOLD-1.
REQ-020 Forced release: in OWN with hold_cnt=MAX_HOLD-1, i_req[owner]=1 and any other i_req bit set, that edge SHALL write o_q and then return to IDLE.
REQ-021 With no other requester pending, the owner SHALL keep ownership indefinitely.
REQ-022 On every exit from OWN, ptr SHALL load (owner+1) modulo N_REQ, wrapping N_REQ-1 to 0.
REQ-023 There SHALL be exactly one IDLE bubble cycle between consecutive owners.
REQ-024 If the owner drops its request on the same edge that forced release applies, REQ-018 SHALL take precedence and o_q SHALL NOT be written.
REQ-025 Request bits of non-owners in OWN SHALL have no effect except triggering forced release.
REQ-026 o_gnt SHALL be one-hot or zero at all times, and o_busy SHALL equal (o_gnt != 0).

Reset
REQ-027 Asserting i_rst low SHALL immediately, without a clock edge, force state=IDLE, o_gnt=0, o_owner=0, o_q=0, ptr=0 and hold_cnt=0.
REQ-028 Reset asserted mid-ownership SHALL abort the ownership, and no o_q write SHALL occur in that cycle.
REQ-029 The first arbitration after reset release SHALL use ptr=0.

Structure
REQ-030 The state enum (IDLE, OWN) SHALL live in a shared package rr_reg_arbiter_pkg, together with the default-parameter constants.
REQ-031 The wrapping priority search SHALL be a sub-module rr_pick: inputs req and ptr; outputs one-hot pick and its index; purely combinational.
REQ-032 The arbiter body SHALL contain the FSM, ptr, hold_cnt and o_q registers, each in an always_ff block with asynchronous active-low reset.

Verification
REQ-033 Reset, then i_req=4'b0100 with data[2]=6'h15 -> o_gnt=4'b0100 one cycle later, and o_q=6'h15 one cycle after that.
REQ-034 i_req=4'b1111 held constant -> owners cycle 0,1,2,3,0, each owning 8 cycles, with one IDLE cycle between owners.
REQ-035 Owner 3 drops its request, and req 0 and 1 are pending -> IDLE, then grant 0 (wrap from 3).
REQ-036 Sole requester 1 held for 20 cycles -> continuous ownership, and o_q tracks data[1] every cycle.
REQ-037 Owner 2 at hold_cnt=7 drops its request on the same cycle that req 0 is pending -> IDLE, o_q unchanged, next grant 0.
REQ-038 i_rst pulsed low mid-OWN between clock edges -> outputs zero immediately, and the first grant after release goes to the lowest pending index.
